// File: rtl/subtractor_4bits_if.sv
// Operand/result bundle for subtractor_4bits.
// Ovf is only present when SUBTRACTOR_4BITS_OVF_EN is defined.
interface subtractor_4bits_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Diff;
    logic       Cout;
`ifdef SUBTRACTOR_4BITS_OVF_EN
    logic       Ovf;
`endif

    // No handshake: the producer holds A/B valid every cycle and the
    // results are valid one clock later, always.
`ifdef SUBTRACTOR_4BITS_OVF_EN
    modport master (output A, output B, input Diff, input Cout, input Ovf);
    modport slave  (input A, input B, output Diff, output Cout, output Ovf);
`else
    modport master (output A, output B, input Diff, input Cout);
    modport slave  (input A, input B, output Diff, output Cout);
`endif
endinterface

// File: rtl/subtractor_4bits.sv
// Registered 4-bit subtractor: Diff = A - B via a ripple of A + ~B + 1, Cout = no-borrow.
// Define SUBTRACTOR_4BITS_OVF_EN to add the registered signed-overflow flag Ovf.
module subtractor_4bits (
    input  logic                clk,
    input  logic                rst_n,
    subtractor_4bits_if.slave   bus
);

    logic [3:0] b_n;
    logic [4:0] carry;
    logic [3:0] diff_d, diff_q;
    logic       cout_d, cout_q;
`ifdef SUBTRACTOR_4BITS_OVF_EN
    logic       ovf_d, ovf_q;
`endif

    always_comb begin
        b_n = ~bus.B;
    end

    // Four full-subtractor cells; the +1 enters as the carry into bit 0.
    always_comb begin
        carry    = '0;
        diff_d   = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            diff_d[i]    = bus.A[i] ^ b_n[i] ^ carry[i];
            carry[i + 1] = (bus.A[i] & b_n[i]) | (bus.A[i] & carry[i]) | (b_n[i] & carry[i]);
        end
        cout_d = carry[4];
    end

`ifdef SUBTRACTOR_4BITS_OVF_EN
    always_comb begin
        ovf_d = carry[4] ^ carry[3];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= 4'b0000;
            cout_q <= 1'b0;
`ifdef SUBTRACTOR_4BITS_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            diff_q <= diff_d;
            cout_q <= cout_d;
`ifdef SUBTRACTOR_4BITS_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign bus.Diff = diff_q;
    assign bus.Cout = cout_q;
`ifdef SUBTRACTOR_4BITS_OVF_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_4bits.sv
// Scoreboard bench for subtractor_4bits: driver pushes expected {Diff,Cout,Ovf}, monitor pops one per edge.
// Ovf is checked only when SUBTRACTOR_4BITS_OVF_EN is defined; otherwise that bit is zero on both sides.
module tb_subtractor_4bits;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [5:0] exp_q[$];

    subtractor_4bits_if bus ();

    subtractor_4bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial begin
        clk   = 1'b0;
        rst_n = 1'b1;
    end
    always #5 clk = ~clk;

    function automatic logic [5:0] act_val();
`ifdef SUBTRACTOR_4BITS_OVF_EN
        return {bus.Diff, bus.Cout, bus.Ovf};
`else
        return {bus.Diff, bus.Cout, 1'b0};
`endif
    endfunction

    function automatic logic ovf_mask(input logic o);
`ifdef SUBTRACTOR_4BITS_OVF_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got diff=%b cout=%b ovf=%b, expected diff=%b cout=%b ovf=%b",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Driver: operands change on the falling edge, expectation queued for the next rising edge
    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic c, input logic o);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        exp_q.push_back({d, c, ovf_mask(o)});
    endtask

    // Monitor: results are present every edge while out of reset
    always @(posedge clk) begin
        logic [5:0] e;
        #1;
        if (rst_n && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pipe", act_val(), e);
        end
    end

    initial begin
        logic [3:0] d;
        logic       c;
        logic       o;
        int         sa, sb, sd;
        int         budget;

        n_checks = 0;
        n_fail   = 0;
        bus.A = 4'b0111;
        bus.B = 4'b0001;

        // Reset held while the clock runs
        #1 rst_n = 1'b0;
        #1 check("reset_async_start", act_val(), 6'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset_held", act_val(), 6'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({4'b0110, 1'b1, 1'b0});

        drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        drive(4'b0111, 4'b0001, 4'b0110, 1'b1, 1'b0);
        drive(4'b0011, 4'b0010, 4'b0001, 1'b1, 1'b0);
        drive(4'b1100, 4'b0011, 4'b1001, 1'b1, 1'b0);

        // Asynchronous reset between edges while Diff = 1001
        @(posedge clk);
        #3;
        check("pre_async_reset", act_val(), {4'b1001, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", act_val(), 6'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("async_reset_held_edge", act_val(), 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({4'b1001, 1'b1, 1'b0});

        // Borrow and signed-overflow corners
        drive(4'b0011, 4'b1100, 4'b0111, 1'b0, 1'b0);
        drive(4'b0111, 4'b1000, 4'b1111, 1'b0, 1'b1);
        drive(4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1);
        drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0);
        drive(4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1);
        drive(4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0);
        drive(4'b0101, 4'b1010, 4'b1011, 1'b0, 1'b1);

        // Exhaustive sweep against an integer model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                d  = 4'((a - b + 16) % 16);
                c  = (a >= b);
                sa = (a > 7) ? a - 16 : a;
                sb = (b > 7) ? b - 16 : b;
                sd = sa - sb;
                o  = (sd > 7) || (sd < -8);
                drive(4'(a), 4'(b), d, c, o);
            end
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subtractor_4bits.md
# subtractor_4bits

Registered 4-bit unsigned/two's-complement subtractor computing Diff = A − B with a carry-out (no-borrow) flag. It is built as a ripple chain of four full-subtractor cells implementing A + ~B + 1, with the result captured in output registers on the rising clock edge. It serves as the arithmetic leaf for small datapaths that need a difference and a magnitude-compare flag in the same cycle.

## Interface
- No parameters; width is fixed at 4 bits.
- clk  input  1  rising-edge clock for the output registers
- rst_n  input  1  asynchronous active-low reset
- A  input  4  minuend
- B  input  4  subtrahend
- Diff  output  4  registered difference, (A − B) mod 16
- Cout  output  1  registered carry-out of A + ~B + 1; 1 = no borrow (A ≥ B unsigned), 0 = borrow (A < B)
- Ovf  output  1  registered signed-overflow flag; present only when SUBTRACTOR_4BITS_OVF_EN is defined

## Operation
- Combinational core: bit i cell computes s_i = A[i] ^ ~B[i] ^ c_i, c_(i+1) = majority(A[i], ~B[i], c_i); c_0 = 1.
- Next Diff = {s3,s2,s1,s0}; next Cout = c_4.
- Unsigned interpretation: Cout = 1 iff A ≥ B; A = B gives Diff = 0000, Cout = 1.
- Signed interpretation: Diff is the two's-complement difference, wrapping mod 16.
- Every input combination is legal; no handshake, no enables; the registers load every clock.
- X/Z on A or B is not defined behaviour; inputs are assumed driven.

## Timing
- Latency: 1 clock. Diff/Cout (and Ovf) reflect the A/B values sampled at the previous rising edge of clk.
- Throughput: one new operand pair per cycle.
- Reset: rst_n low immediately (asynchronously) forces Diff = 0000, Cout = 0, Ovf = 0, independent of clk.
- Reset release: first rising edge with rst_n high loads the result for the current A/B.
- Reset asserted mid-stream discards any pending result; no partial state survives.
- Outputs are glitch-free between edges (driven directly from flops).
- Combinational path A/B → register D is a 4-stage ripple; it must close within one clk period.

## Configuration
- SUBTRACTOR_4BITS_OVF_EN defined: port Ovf exists; next Ovf = c_4 ^ c_3 (equivalently A[3] ≠ B[3] and Diff[3] ≠ A[3]); registered with the same latency and reset value 0 as Diff.
- SUBTRACTOR_4BITS_OVF_EN undefined: no Ovf port and no overflow logic; Diff/Cout behaviour is identical.

## Test plan
- Hold rst_n = 0 with A = 0111, B = 0001 and toggle clk → Diff = 0000, Cout = 0 throughout; on release, next edge → Diff = 0110, Cout = 1.
- A = 0000, B = 0000 → one edge later Diff = 0000, Cout = 1.
- Sequence A/B = 0111/0001, 0011/0010, 1100/0011 on consecutive edges → Diff = 0110, 0001, 1001, each with Cout = 1, each appearing one cycle after its operands.
- A = 0011, B = 1100 → Diff = 0111, Cout = 0 (borrow); with OVF_EN, Ovf = 0 (3 − (−4) = 7).
- With OVF_EN: A = 0111, B = 1000 → Diff = 1111, Cout = 0, Ovf = 1; A = 1000, B = 0001 → Diff = 0111, Cout = 1, Ovf = 1.
- Assert rst_n low asynchronously between edges while Diff = 1001 → Diff = 0000, Cout = 0 immediately, without waiting for clk; exhaustive 256-pair sweep then matches (A − B) mod 16 and A ≥ B.
